// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_sequencer_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  // One instruction is four bytes from a byte-wide memory
  localparam int BYTES_PER_INSTR = 4;

  // PC advance per accepted instruction
  localparam int PC_INCR = 4;

  // Clears the two low address bits to force word alignment (sliced to ADDR_W by users)
  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Memory-side and decode-side signals of the fetch sequencer.
// master = the sequencer, slave = memory/decode/branch environment.
interface instr_fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              run;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    input  run,
    input  mem_rdata,
    input  instr_ready,
    input  branch_valid,
    input  branch_target,
    output mem_rd_en,
    output mem_addr,
    output instr,
    output instr_pc,
    output instr_valid
  );

  modport slave (
    output run,
    output mem_rdata,
    output instr_ready,
    output branch_valid,
    output branch_target,
    input  mem_rd_en,
    input  mem_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid
  );
endinterface

// File: rtl/instr_byte_assembler.sv
// Big-endian byte assembler: collects the first three bytes of an instruction
// and presents them, joined with the byte currently on the bus, as a 32-bit word.
module instr_byte_assembler
  import instr_fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [2:0]  o_count
);

  // The last byte never needs storage: it goes straight into the instruction register
  localparam int HELD_BYTES = BYTES_PER_INSTR - 1;

  logic [8*HELD_BYTES-1:0] r_bytes;
  logic [2:0]              r_count;

  // Shift in one byte per qualified load; clear has priority and drops partial words
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_bytes <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_bytes <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_bytes <= {r_bytes[8*HELD_BYTES-9:0], i_byte};
      r_count <= r_count + 3'd1;
    end
  end

  assign o_word  = {r_bytes, i_byte};
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues four byte reads per
// instruction, assembles them big-endian and hands the word to decode.
module instr_fetch_sequencer
  import instr_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     nreset,
  instr_fetch_sequencer_if.master  bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [1:0]        r_issue_cnt;
  logic [1:0]        w_issue_cnt_next;
  logic              w_load_instr;

  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_pend;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;

  logic              w_handshake;
  logic              w_branch;
  logic [ADDR_W-1:0] w_target;
  logic              w_asm_clear;
  logic [31:0]       w_asm_word;
  logic [2:0]        w_byte_cnt;
  logic              w_last_byte;

  assign w_handshake = r_instr_valid && bus.instr_ready;
  assign w_branch    = bus.branch_valid;
  assign w_target    = bus.branch_target & ALIGN_MASK[ADDR_W-1:0];
  assign w_last_byte = r_pend && (w_byte_cnt == 3'(BYTES_PER_INSTR - 1));
  assign w_asm_clear = w_branch || w_load_instr;

  instr_byte_assembler u_asm (
    .clk     (clk),
    .nreset  (nreset),
    .i_clear (w_asm_clear),
    .i_load  (r_pend),
    .i_byte  (bus.mem_rdata),
    .o_word  (w_asm_word),
    .o_count (w_byte_cnt)
  );

  // State, PC and issue counter registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_issue_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_issue_cnt <= w_issue_cnt_next;
    end
  end

  // Next-state logic; a branch overrides every other transition
  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_issue_cnt_next = r_issue_cnt;
    w_load_instr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.run) begin
          w_state_next     = ISSUE;
          w_issue_cnt_next = '0;
        end
      end
      ISSUE: begin
        if (r_issue_cnt == 2'(BYTES_PER_INSTR - 1)) begin
          w_state_next     = DRAIN;
          w_issue_cnt_next = '0;
        end else begin
          w_issue_cnt_next = r_issue_cnt + 2'd1;
        end
      end
      DRAIN: begin
        if (w_last_byte) begin
          w_state_next = VALID;
          w_load_instr = 1'b1;
        end
      end
      VALID: begin
        if (w_handshake) begin
          w_pc_next        = r_pc + ADDR_W'(PC_INCR);
          w_state_next     = bus.run ? ISSUE : IDLE;
          w_issue_cnt_next = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (w_branch) begin
      w_pc_next        = w_target;
      w_state_next     = bus.run ? ISSUE : IDLE;
      w_issue_cnt_next = '0;
      w_load_instr     = 1'b0;
    end
  end

  // Registered outputs: read strobe/address lead the state so they line up with ISSUE cycles
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_mem_rd_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_pend        <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_mem_rd_en <= (w_state_next == ISSUE);
      // PC is word aligned, so OR-ing the byte index never carries
      if (w_state_next == ISSUE) begin
        r_mem_addr <= w_pc_next | ADDR_W'(w_issue_cnt_next);
      end
      r_pend <= w_branch ? 1'b0 : r_mem_rd_en;
      if (w_load_instr) begin
        r_instr    <= w_asm_word;
        r_instr_pc <= r_pc;
      end
      if (w_branch || w_handshake) begin
        r_instr_valid <= 1'b0;
      end else if (w_load_instr) begin
        r_instr_valid <= 1'b1;
      end
    end
  end

  assign bus.mem_rd_en   = r_mem_rd_en;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Controls the byte-wide, big-endian instruction memory for the single-cycle ARM datapath.
- Owns the program counter and issues four byte reads per instruction.
- Assembles the returned bytes into a 32-bit instruction and presents it to decode with a valid/ready handshake.
- Handles branch redirects by aborting the in-flight fetch and restarting at the target.

Parameters:
- ADDR_W, 32, width of PC and memory byte address; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset; low two bits must be 0.

Ports:
- clk  input  1  system clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- run  input  1  fetch enable; when low, no new fetch starts.
- mem_rd_en  output  1  byte read strobe to instruction memory.
- mem_addr  output  ADDR_W  byte address of the current read.
- mem_rdata  input  8  read byte; valid exactly one cycle after mem_rd_en.
- instr  output  32  assembled instruction; byte at pc+0 lands in [31:24], byte at pc+3 in [7:0].
- instr_pc  output  ADDR_W  address of instr.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts; the transfer completes when instr_valid && instr_ready.
- branch_valid  input  1  redirect request, single-cycle pulse.
- branch_target  input  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - pc = RESET_PC, state IDLE.
  - mem_rd_en = 0, mem_addr = 0, instr_valid = 0, instr = 0, instr_pc = 0.
  - byte count = 0, pending flag = 0.
- State machine:
  - IDLE: when run = 1, go to ISSUE next cycle.
  - ISSUE: 4 consecutive cycles with mem_rd_en = 1 and mem_addr = pc+0, pc+1, pc+2, pc+3 (issue counter 0..3). After the 4th issue, go to DRAIN.
  - DRAIN: capture the final byte. Then go to VALID with instr_valid = 1 and instr_pc = pc.
  - VALID: hold instr/instr_pc stable until the handshake. On handshake, pc += 4 and go to ISSUE if run = 1, else IDLE.
- Latency: first mem_rd_en in cycle N; bytes captured at the ends of N+1..N+4; instr_valid high from cycle N+5.
  - After a handshake in cycle M, the next mem_rd_en is in cycle M+1.
- Byte capture: mem_rdata is taken only when the pending flag (registered copy of mem_rd_en, cleared on redirect) is set. Bytes shift left into a 32-bit assembly register.
- mem_rd_en is low in IDLE, DRAIN and VALID. mem_addr holds its last value when not reading.
- run deasserted mid-ISSUE: the current instruction completes normally; the block stops only at the IDLE/VALID decision point.
- branch_valid, any state:
  - pc <= {branch_target[ADDR_W-1:2], 2'b00}.
  - Assembly register and counters are cleared; pending flag is cleared, so the byte returning next cycle is discarded.
  - instr_valid goes low next cycle.
  - State goes to ISSUE (run = 1) or IDLE (run = 0) next cycle; the first new mem_rd_en is the cycle after branch_valid.
- branch_valid coincident with a handshake: the handshake counts as accepted, and the branch target wins over pc+4.
- Wrap: pc = 2^ADDR_W−4 followed by +4 gives 0. Byte addresses pc+1..pc+3 never cross the boundary because pc is word-aligned.
- No output is combinationally dependent on instr_ready or branch_valid; all outputs are registered.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ISSUE, DRAIN, VALID};
  - BYTES_PER_INSTR = 4;
  - PC_INCR = 4;
  - ALIGN_MASK for word alignment.
- One natural sub-module, instr_byte_assembler: pending-qualified 8→32 big-endian shift register with clear, load and byte-count outputs.

Test Plan:
- Reset then run = 1 with memory bytes 00,00,00,00,e3,a0,00,08: first instr = 0x00000000 at pc 0, valid at cycle 5 after first rd_en. After accept, instr = 0xe3a00008 with instr_pc = 4.
- Hold instr_ready = 0 for 10 cycles in VALID: instr, instr_pc and instr_valid stay stable, and mem_rd_en stays 0 throughout.
- branch_valid with target 0x13 asserted during the 3rd ISSUE cycle: next reads are at 0x10..0x13, the stale byte is discarded, and the result is the word at 0x10.
- branch_valid (target 0x20) in the same cycle as a handshake at pc 8: the next instr_pc is 0x20, not 0xC.
- ADDR_W = 8, pc = 0xFC, accept: next fetch reads addresses 0x00..0x03.
- nreset asserted mid-ISSUE: outputs are immediately at reset values, and fetch restarts at RESET_PC after release with run = 1.
